imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Byte-stream program loader: writes the instruction memory that the pipeline's IF stage reads.
- Accepts a framed byte stream over a valid/ready handshake and assembles 32-bit big-endian words.
- Drives a word-wide memory write port into the instruction memory.
- Holds the pipeline (cpu_hold) until the image is loaded and its checksum verifies.

Parameters:
ADDR_WIDTH, 8, word-address width of the instruction memory write port
DEPTH, 256, maximum words accepted (must be <= 2**ADDR_WIDTH)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets)
start  input  1  one-cycle pulse: begin a new load frame
in_data  input  8  stream byte
in_valid  input  1  in_data is valid
in_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  instruction memory write enable, one-cycle pulse per word
mem_addr  output  ADDR_WIDTH  word address of write
mem_wdata  output  32  word to write
cpu_hold  output  1  hold pipeline PC/IF_ID while high
done  output  1  image loaded and checksum matched
error  output  1  frame rejected (count too large or checksum mismatch)
words_loaded  output  ADDR_WIDTH+1  number of payload words written in the current frame

Behaviour:
- Frame format: 4-byte count N (MSB first), then N payload words (MSB first), then a 4-byte checksum. Checksum = sum of payload words mod 2^32.
- Byte accepted iff in_valid && in_ready at a rising edge.
- A word completes on its 4th accepted byte. Gaps in in_valid are allowed anywhere.
- Reset (reset==0): state IDLE, byte counter 0, and all outputs 0 (in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_loaded).
- Reset mid-frame aborts the frame immediately. Writes already issued to memory are not undone.
- States:
  - IDLE: in_ready=0, cpu_hold=0. start -> HEADER.
  - HEADER: in_ready=1, cpu_hold=1. On the 4th byte: N==0 -> CHECK; N>DEPTH -> ERROR; otherwise -> PAYLOAD.
  - PAYLOAD: in_ready=1, cpu_hold=1. Each completed word:
    - mem_we=1 in the next cycle, with mem_addr=words_loaded (old value) and mem_wdata=word.
    - words_loaded increments in that same cycle.
    - The running sum is updated.
    - After word N -> CHECK. The last word's write pulse occurs during the first CHECK cycle.
  - CHECK: in_ready=1, cpu_hold=1. On the 4th byte: received==sum -> DONE; otherwise -> ERROR.
  - DONE: done=1, cpu_hold=0, in_ready=0.
  - ERROR: error=1, cpu_hold=1, in_ready=0.
- Latency: DONE/ERROR outputs are visible the cycle after the accepting edge of the final byte.
- Entering HEADER from any state clears done, error, words_loaded, the sum and the byte counter. cpu_hold rises in the same cycle as the transition.
- start is ignored in HEADER, PAYLOAD and CHECK.
- start in IDLE, DONE or ERROR -> HEADER.
- Simultaneous start and in_valid on the start cycle: the byte is not accepted, because in_ready is still 0.
- mem_we is never asserted outside PAYLOAD and the first CHECK cycle.
- mem_addr and mem_wdata hold their last value when mem_we=0.
- Sum arithmetic is 32-bit and wraps. N is compared as a full 32-bit unsigned value against DEPTH.

Decomposition:
- Shared package/include imem_loader_defs:
  - State encoding (IDLE, HEADER, PAYLOAD, CHECK, DONE, ERROR)
  - BYTES_PER_WORD=4
- Sub-module byte_assembler:
  - 8-to-32 shift register with a 2-bit byte counter and word_valid pulse; clear input driven on HEADER entry.
  - Used for the count, payload and checksum fields.

Test Plan:
- Basic load:
  - Stimulus: start, then bytes 00 00 00 02 | 20 08 00 05 | 01 09 50 20 | 21 11 50 25.
  - Response: two mem_we pulses, (addr 0, 0x20080005) and (addr 1, 0x01095020); words_loaded=2; done=1; cpu_hold=0.
- Backpressure gaps:
  - Stimulus: same frame with in_valid low 3 cycles between every byte.
  - Response: identical writes and done=1; in_ready stays 1 throughout the frame.
- Zero count:
  - Stimulus: header 00000000, checksum 00000000.
  - Response: no mem_we pulses; done=1.
  - Then repeat with checksum 00000001 -> error=1, cpu_hold=1.
- Oversize count:
  - Stimulus: header 00000101 with DEPTH=256.
  - Response: error=1 the cycle after the 4th byte; in_ready=0; no writes.
- Bad checksum:
  - Stimulus: basic frame with checksum 21115026.
  - Response: both writes occur; error=1; done=0; cpu_hold=1.
  - Then a new start with a valid frame -> done=1.
- Reset and start mid-frame:
  - Stimulus: reset=0 after 6 payload bytes.
  - Response: all outputs 0 the next cycle.
  - Separately, a start pulse during PAYLOAD changes nothing and the frame completes normally.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and framing constants for the program loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loaderState_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_COUNT_W   = $clog2(BYTES_PER_WORD);
  localparam logic [BYTE_COUNT_W-1:0] LAST_BYTE = BYTE_COUNT_W'(BYTES_PER_WORD - 1);

  // A new frame may only be opened when no frame is in flight.
  function automatic logic canStart(input loaderState_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// rtl/imem_loader_byte_assembler.sv - big-endian 8-to-32 bit word assembler
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  byteData,
  input  logic        byteValid,
  output logic [31:0] word,
  output logic        wordValid
);

  logic [23:0]             shiftReg;
  logic [BYTE_COUNT_W-1:0] byteCount;

  // The word is presented together with its final byte so the caller can act
  // on the same edge that accepts that byte.
  assign wordValid = byteValid && (byteCount == LAST_BYTE);
  assign word      = {shiftReg, byteData};

  // Shift in accepted bytes MSB first; counter wraps naturally after each word.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      shiftReg  <= '0;
      byteCount <= '0;
    end else if (byteValid) begin
      shiftReg  <= {shiftReg[15:0], byteData};
      byteCount <= byteCount + BYTE_COUNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader that writes instruction memory and holds the CPU
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [31:0]         DEPTH_W = 32'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);

  loaderState_t          state;
  logic [31:0]           sum;
  logic [ADDR_WIDTH:0]   frameCount;
  logic [ADDR_WIDTH:0]   nextLoaded;
  logic                  byteAccept;
  logic                  headerEntry;
  logic [31:0]           word;
  logic                  wordValid;

  assign byteAccept  = in_valid && in_ready;
  assign headerEntry = start && canStart(state);
  assign nextLoaded  = words_loaded + ONE;

  byte_assembler u_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (headerEntry),
    .byteData  (in_data),
    .byteValid (byteAccept),
    .word      (word),
    .wordValid (wordValid)
  );

  // Frame sequencer: all outputs are registered alongside the state so that
  // handshake, hold and status change on the same edge as the transition.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      sum          <= '0;
      frameCount   <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state        <= ST_HEADER;
            in_ready     <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            sum          <= '0;
            frameCount   <= '0;
          end
        end

        ST_HEADER: begin
          if (wordValid) begin
            if (word == 32'd0) begin
              state <= ST_CHECK;
            end else if (word > DEPTH_W) begin
              state    <= ST_ERROR;
              error    <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              state      <= ST_PAYLOAD;
              frameCount <= word[ADDR_WIDTH:0];
            end
          end
        end

        ST_PAYLOAD: begin
          if (wordValid) begin
            mem_we       <= 1'b1;
            mem_addr     <= words_loaded[ADDR_WIDTH-1:0];
            mem_wdata    <= word;
            words_loaded <= nextLoaded;
            sum          <= sum + word;
            if (nextLoaded == frameCount) begin
              state <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          if (wordValid) begin
            in_ready <= 1'b0;
            if (word == sum) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
        end

        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader with a frame-level reference model
module tb_imem_loader;

  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]     frameQ[$];
  logic [31:0]    payload[$];
  logic [AW+31:0] gotQ[$];
  logic [AW+31:0] expQ[$];
  logic           expDone;
  logic           expErr;
  logic [AW:0]    expWords;

  // Capture every memory write the DUT issues.
  always @(negedge clk) begin
    if (mem_we) gotQ.push_back({mem_addr, mem_wdata});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic pushWord(input logic [31:0] w);
    frameQ.push_back(w[31:24]);
    frameQ.push_back(w[23:16]);
    frameQ.push_back(w[15:8]);
    frameQ.push_back(w[7:0]);
  endtask

  task automatic fillPayload(input int n);
    payload.delete();
    for (int i = 0; i < n; i++) payload.push_back($urandom);
  endtask

  // Reference model: frame bytes plus the expected writes and final status.
  task automatic buildFrame(input logic [31:0] n, input logic [31:0] csumAdj);
    logic [31:0] s;
    logic [31:0] idx;
    s = 32'd0;
    frameQ.delete();
    expQ.delete();
    pushWord(n);
    if (n > DEPTH) begin
      expDone  = 1'b0;
      expErr   = 1'b1;
      expWords = '0;
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      idx = i;
      pushWord(payload[i]);
      s = s + payload[i];
      expQ.push_back({idx[AW-1:0], payload[i]});
    end
    pushWord(s + csumAdj);
    expDone  = (csumAdj == 32'd0);
    expErr   = !expDone;
    expWords = n[AW:0];
  endtask

  task automatic doStart(input logic withByte);
    @(negedge clk);
    start    = 1'b1;
    in_valid = withByte;
    in_data  = 8'hA5;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    chk("start:cpu_hold", cpu_hold, 1);
    chk("start:in_ready", in_ready, 1);
    chk("start:done", done, 0);
    chk("start:error", error, 0);
    chk("start:words_loaded", words_loaded, 0);
  endtask

  task automatic sendBytes(input int lo, input int hi, input int gap);
    for (int k = lo; k < hi; k++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        in_valid = 1'b0;
        chk("gap:in_ready", in_ready, 1);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frameQ[k];
      chk("byte:in_ready", in_ready, 1);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic finishFrame(input string tag);
    chk({tag, ":done"}, done, expDone);
    chk({tag, ":error"}, error, expErr);
    chk({tag, ":cpu_hold"}, cpu_hold, !expDone);
    chk({tag, ":in_ready"}, in_ready, 0);
    chk({tag, ":words_loaded"}, words_loaded, expWords);
    chk({tag, ":nwrites"}, gotQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
      chk({tag, ":write"}, gotQ[i], expQ[i]);
    gotQ.delete();
  endtask

  task automatic runFrame(input string tag, input logic [31:0] n, input logic [31:0] adj,
                          input int gap, input logic withByte);
    buildFrame(n, adj);
    doStart(withByte);
    sendBytes(0, frameQ.size(), gap);
    finishFrame(tag);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst:in_ready", in_ready, 0);
    chk("rst:mem_we", mem_we, 0);
    chk("rst:mem_addr", mem_addr, 0);
    chk("rst:mem_wdata", mem_wdata, 0);
    chk("rst:cpu_hold", cpu_hold, 0);
    chk("rst:done", done, 0);
    chk("rst:error", error, 0);
    chk("rst:words_loaded", words_loaded, 0);
    reset = 1'b1;
    @(negedge clk);

    payload = {32'h20080005, 32'h01095020};
    runFrame("basic", 32'd2, 32'd0, 0, 1'b1);
    runFrame("gaps", 32'd2, 32'd0, 3, 1'b0);

    payload.delete();
    runFrame("zero", 32'd0, 32'd0, 0, 1'b0);
    runFrame("zero_bad", 32'd0, 32'd1, 1, 1'b0);

    runFrame("oversize", 32'h00000101, 32'd0, 0, 1'b0);
    runFrame("oversize_big", 32'h80000000, 32'd0, 0, 1'b0);

    payload = {32'h20080005, 32'h01095020};
    runFrame("bad_csum", 32'd2, 32'd1, 0, 1'b0);
    runFrame("recover", 32'd2, 32'd0, 0, 1'b0);

    // Reset after six payload bytes: one word already written, then all outputs drop.
    buildFrame(32'd2, 32'd0);
    doStart(1'b0);
    sendBytes(0, 10, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst:in_ready", in_ready, 0);
    chk("midrst:mem_we", mem_we, 0);
    chk("midrst:mem_addr", mem_addr, 0);
    chk("midrst:mem_wdata", mem_wdata, 0);
    chk("midrst:cpu_hold", cpu_hold, 0);
    chk("midrst:done", done, 0);
    chk("midrst:error", error, 0);
    chk("midrst:words_loaded", words_loaded, 0);
    chk("midrst:nwrites", gotQ.size(), 1);
    gotQ.delete();
    reset = 1'b1;
    @(negedge clk);

    // A start pulse in the middle of the payload is ignored.
    buildFrame(32'd2, 32'd0);
    doStart(1'b0);
    sendBytes(0, 6, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("midstart:cpu_hold", cpu_hold, 1);
    sendBytes(6, frameQ.size(), 1);
    finishFrame("midstart");

    fillPayload(DEPTH);
    runFrame("full_depth", DEPTH, 32'd0, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int n;
      logic [31:0] adj;
      n = $urandom_range(1, 8);
      fillPayload(n);
      adj = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 255)) : 32'd0;
      runFrame("random", n, adj, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
